// File: rtl/fp16_pkg.sv
// Constants and types shared by the FP16 multiplier stages.
package fp16_pkg;

    localparam int EXP_W = 5;
    localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
    localparam int MAN_W = 10;

    // Wide enough to hold expA + expB - BIAS + inc without wrap.
    typedef logic signed [EXP_W+1:0] exp_ext_t;

endpackage

// File: rtl/csa_row.sv
// 3:2 carry-save compressor: one full adder per bit, carry vector left unshifted.
module csa_row #(
    parameter int W = 7
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [W-1:0] i_c,
    output logic [W-1:0] o_sum,
    output logic [W-1:0] o_carry
);

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_fa
            assign o_sum[gi]   = i_a[gi] ^ i_b[gi] ^ i_c[gi];
            assign o_carry[gi] = (i_a[gi] & i_b[gi]) | (i_a[gi] & i_c[gi]) | (i_b[gi] & i_c[gi]);
        end
    endgenerate

endmodule

// File: rtl/csa_exp_adder.sv
// FP16 multiplier exponent stage: expA + expB - BIAS + inc, registered with range flags.
module csa_exp_adder #(
    parameter int EXP_W = fp16_pkg::EXP_W,
    parameter int BIAS  = fp16_pkg::BIAS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [EXP_W-1:0] expA,
    input  logic [EXP_W-1:0] expB,
    input  logic             inc,
    output logic             out_valid,
    output logic [EXP_W-1:0] exp,
    output logic             ovf,
    output logic             unf
);

    localparam int EXT_W = EXP_W + 2;
    localparam logic [EXT_W-1:0] NEG_BIAS = EXT_W'(-BIAS);
    localparam logic [EXT_W-2:0] OVF_TH   = (EXT_W-1)'((1 << EXP_W) - 1);

    logic [EXT_W-1:0] w_a;
    logic [EXT_W-1:0] w_b;
    logic [EXT_W-1:0] w_sum;
    logic [EXT_W-1:0] w_carry;
    logic [EXT_W-1:0] w_r;
    logic             w_ovf;
    logic             w_unf;
    logic             w_unused_carry_msb;

    logic             r_valid;
    logic [EXP_W-1:0] r_exp;
    logic             r_ovf;
    logic             r_unf;

    assign w_a = {2'b00, expA};
    assign w_b = {2'b00, expB};

    csa_row #(
        .W (EXT_W)
    ) u_csa_row (
        .i_a     (w_a),
        .i_b     (w_b),
        .i_c     (NEG_BIAS),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    // The carry MSB shifts out of the internal width; the result never needs it.
    assign w_unused_carry_msb = w_carry[EXT_W-1];

    assign w_r = w_sum + {w_carry[EXT_W-2:0], 1'b0} + {{(EXT_W-1){1'b0}}, inc};

    // w_r is two's complement: MSB set means negative.
    assign w_ovf = ~w_r[EXT_W-1] & (w_r[EXT_W-2:0] >= OVF_TH);
    assign w_unf = w_r[EXT_W-1] | (w_r == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_exp   <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_valid <= in_valid;
            r_exp   <= w_r[EXP_W-1:0];
            r_ovf   <= w_ovf;
            r_unf   <= w_unf;
        end
    end

    assign out_valid = r_valid;
    assign exp       = r_exp;
    assign ovf       = r_ovf;
    assign unf       = r_unf;

endmodule

// File: tb/tb_csa_exp_adder.sv
// Scoreboard bench for csa_exp_adder: directed boundary cases, then a random stream with a mid-stream reset.
module tb_csa_exp_adder;
    import fp16_pkg::*;

    typedef struct packed {
        logic             valid;
        logic [EXP_W-1:0] exp;
        logic             ovf;
        logic             unf;
    } exp_res_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [EXP_W-1:0] expA;
    logic [EXP_W-1:0] expB;
    logic             inc;
    logic             out_valid;
    logic [EXP_W-1:0] dut_exp;
    logic             ovf;
    logic             unf;

    exp_res_t sb_q[$];
    int       n_checks;
    int       n_pass;

    csa_exp_adder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .expA      (expA),
        .expB      (expB),
        .inc       (inc),
        .out_valid (out_valid),
        .exp       (dut_exp),
        .ovf       (ovf),
        .unf       (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    endtask

    function automatic exp_res_t model(input int a, input int b, input int i, input logic v);
        exp_res_t res;
        exp_ext_t r;
        r         = exp_ext_t'(a + b - BIAS + i);
        res.valid = v;
        res.exp   = r[EXP_W-1:0];
        res.ovf   = (r >= exp_ext_t'((1 << EXP_W) - 1));
        res.unf   = (r <= 0);
        return res;
    endfunction

    task automatic check_outputs(input string tag);
        exp_res_t want;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        want = sb_q.pop_front();
        check({tag, "_valid"}, 32'(out_valid), 32'(want.valid));
        check({tag, "_exp"},   32'(dut_exp),   32'(want.exp));
        check({tag, "_ovf"},   32'(ovf),       32'(want.ovf));
        check({tag, "_unf"},   32'(unf),       32'(want.unf));
    endtask

    task automatic drive(input int a, input int b, input int i, input logic v);
        expA     = EXP_W'(a);
        expB     = EXP_W'(b);
        inc      = i[0];
        in_valid = v;
        sb_q.push_back(model(a, b, i, v));
    endtask

    task automatic step(input string tag, input int a, input int b, input int i, input logic v);
        @(negedge clk);
        drive(a, b, i, v);
        @(posedge clk);
        #1;
        $display("txn %s: A=%0d B=%0d inc=%0d vin=%0d -> vout=%0d exp=%0d ovf=%0d unf=%0d",
                 tag, a, b, i, v, out_valid, dut_exp, ovf, unf);
        check_outputs(tag);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_exp"},   32'(dut_exp),   32'd0);
        check({tag, "_ovf"},   32'(ovf),       32'd0);
        check({tag, "_unf"},   32'(unf),       32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        expA     = 5'd30;
        expB     = 5'd30;
        inc      = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");

        @(negedge clk);
        rst_n = 1'b1;

        // Directed values with hand-derived expectations.
        step("mid",       15, 15, 0, 1'b1);
        check("mid_exp_const", 32'(dut_exp), 32'd15);
        step("mid_inc",   15, 15, 1, 1'b1);
        check("mid_inc_exp_const", 32'(dut_exp), 32'd16);
        step("mix",        7, 17, 0, 1'b1);
        check("mix_exp_const", 32'(dut_exp), 32'd9);
        step("mix_inc",    7, 17, 1, 1'b1);
        check("mix_inc_exp_const", 32'(dut_exp), 32'd10);
        step("ovf45",     30, 30, 0, 1'b1);
        check("ovf45_exp_const", 32'(dut_exp), 32'd13);
        check("ovf45_ovf_const", 32'(ovf), 32'd1);
        step("ovf31",     23, 23, 0, 1'b1);
        check("ovf31_exp_const", 32'(dut_exp), 32'd31);
        check("ovf31_ovf_const", 32'(ovf), 32'd1);
        step("unf_m13",    1,  1, 0, 1'b1);
        check("unf_m13_exp_const", 32'(dut_exp), 32'd19);
        check("unf_m13_unf_const", 32'(unf), 32'd1);
        step("unf_zero",   8,  7, 0, 1'b1);
        check("unf_zero_exp_const", 32'(dut_exp), 32'd0);
        check("unf_zero_unf_const", 32'(unf), 32'd1);
        step("min",        0,  0, 0, 1'b1);
        check("min_exp_const", 32'(dut_exp), 32'd17);
        step("max",       31, 31, 1, 1'b1);
        check("max_exp_const", 32'(dut_exp), 32'd16);
        check("max_ovf_const", 32'(ovf), 32'd1);
        step("edge30",    15, 30, 0, 1'b1);
        step("edge1",      8,  8, 0, 1'b1);
        step("idle",      20, 20, 0, 1'b0);

        // Random stream; asynchronous reset pulse between clock edges half way.
        for (int n = 0; n < 200; n++) begin
            if (n == 100) begin
                @(negedge clk);
                drive($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 1), 1'b1);
                #2;
                rst_n = 1'b0;
                #1;
                check_zero("async_rst");
                #1;
                rst_n = 1'b1;
                @(posedge clk);
                #1;
                check_outputs("post_rst");
            end else begin
                step("rnd", $urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom_range(0, 1), 1'($urandom_range(0, 1)));
            end
        end

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
